random_generator_param: RTL and testbench

Parametrised Galois LFSR pseudo-random source that replaces the fixed 12-bit auto-running generator used by the game logic. It adds configurable width, feedback taps and seed, a step enable, runtime reseeding, and a request/valid "draw" port. The draw port returns a value uniformly limited to an inclusive range [0, DRAW_MAX] by rejection sampling, for spawn positions, enemy choices and similar game events.

---
 rtl/random_generator_param.sv | 153 +++++++++++++++
 tb/tb_random_generator_param.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_generator_param.sv
// random_generator_param: parametrised Galois LFSR pseudo-random source with
// step enable, runtime reseeding and a ranged request/valid draw port.
//
// Optional feature macro: RNG_ZERO_GUARD_EN
//   defined   - a zero seed_in on seed_load is replaced by SEED and seed_reject
//               pulses, so the LFSR can never lock up at zero.
//   undefined - seed_in is loaded as-is (zero locks the LFSR); seed_reject = 0.
//
// Parameters:
//   WIDTH     - LFSR and result width (4..32)
//   TAPS      - Galois feedback mask; bit 0 ignored, MSB always rotates to bit 0
//   SEED      - reset value and zero-guard substitute (non-zero)
//   MAX_TRIES - draw evaluations before the halved fallback is returned (>= 1)
//
// Ports:
//   clk, rst_n     - rising-edge clock, asynchronous active-low reset
//   step_en        - advance the LFSR one step (when no draw uses it)
//   seed_load      - load seed_in into the LFSR (highest priority)
//   seed_in        - seed value
//   random_result  - current LFSR state
//   draw_req       - request a ranged draw, sampled only while not busy
//   draw_max       - inclusive upper bound, latched on acceptance
//   draw_busy      - draw in progress
//   draw_valid     - one-cycle pulse, draw_result updated
//   draw_result    - ranged result, held until the next draw completes
//   seed_reject    - one-cycle pulse, zero seed replaced by SEED

module random_generator_param #(
  parameter int unsigned       WIDTH     = 12,
  parameter logic [WIDTH-1:0]  TAPS      = WIDTH'(12'h092),
  parameter logic [WIDTH-1:0]  SEED      = WIDTH'(12'h689),
  parameter int unsigned       MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] random_result,
  input  logic             draw_req,
  input  logic [WIDTH-1:0] draw_max,
  output logic             draw_busy,
  output logic             draw_valid,
  output logic [WIDTH-1:0] draw_result,
  output logic             seed_reject
);

  localparam int unsigned      TRIES_W  = $clog2(MAX_TRIES) + 1;
  localparam logic [WIDTH-1:0] FB_MASK  = TAPS & ~WIDTH'(1);
  localparam logic [TRIES_W-1:0] LAST_TRY = TRIES_W'(MAX_TRIES - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DRAW = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   max_q;
  logic [WIDTH-1:0]   mask_q;
  logic [TRIES_W-1:0] tries;

  logic [WIDTH-1:0]   lfsr_next_c;
  logic [WIDTH-1:0]   range_mask_c;
  logic [WIDTH-1:0]   cand_c;
  logic [WIDTH-1:0]   load_value_c;
  logic               accept_c;

  // One Galois step: rotate left, XOR taps in when the old MSB was set.
  assign lfsr_next_c = {random_result[WIDTH-2:0], random_result[WIDTH-1]}
                     ^ ({WIDTH{random_result[WIDTH-1]}} & FB_MASK);

  // Smear the highest set bit downwards: smallest 2^k-1 covering draw_max.
  always_comb begin
    range_mask_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      range_mask_c = range_mask_c | (draw_max >> i);
    end
  end

  assign cand_c    = random_result & mask_q;
  assign accept_c  = (state == ST_IDLE) && draw_req;
  assign draw_busy = (state == ST_DRAW);

`ifdef RNG_ZERO_GUARD_EN
  logic seed_zero_c;

  assign seed_zero_c  = (seed_in == '0);
  assign load_value_c = seed_zero_c ? SEED : seed_in;

  // Flag a substituted zero seed in the cycle after the load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reject <= 1'b0;
    end else begin
      seed_reject <= seed_load && seed_zero_c;
    end
  end
`else
  assign load_value_c = seed_in;
  assign seed_reject  = 1'b0;
`endif

  // LFSR: load beats draw stepping, which beats step_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_result <= SEED;
    end else if (seed_load) begin
      random_result <= load_value_c;
    end else if ((state == ST_DRAW) || accept_c || step_en) begin
      random_result <= lfsr_next_c;
    end
  end

  // Draw FSM: accept, then evaluate one masked candidate per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      max_q       <= '0;
      mask_q      <= '0;
      tries       <= '0;
      draw_valid  <= 1'b0;
      draw_result <= '0;
    end else begin
      draw_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (draw_req) begin
            state  <= ST_DRAW;
            max_q  <= draw_max;
            mask_q <= range_mask_c;
            tries  <= '0;
          end
        end
        ST_DRAW: begin
          if (cand_c <= max_q) begin
            draw_result <= cand_c;
            draw_valid  <= 1'b1;
            state       <= ST_IDLE;
          end else if (tries == LAST_TRY) begin
            // cand < 2*(mask>>1)+2 <= 2*max+... so cand>>1 never exceeds max.
            draw_result <= cand_c >> 1;
            draw_valid  <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            tries <= tries + TRIES_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_random_generator_param.sv
// Self-checking bench for random_generator_param (default parameters).
module tb_random_generator_param;

  localparam int unsigned MT = 8;

  logic        clk;
  logic        rst_n;
  logic        step_en;
  logic        seed_load;
  logic [11:0] seed_in;
  logic [11:0] random_result;
  logic        draw_req;
  logic [11:0] draw_max;
  logic        draw_busy;
  logic        draw_valid;
  logic [11:0] draw_result;
  logic        seed_reject;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  random_generator_param dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .step_en       (step_en),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .random_result (random_result),
    .draw_req      (draw_req),
    .draw_max      (draw_max),
    .draw_busy     (draw_busy),
    .draw_valid    (draw_valid),
    .draw_result   (draw_result),
    .seed_reject   (seed_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_le(input string nm, input logic [31:0] act, input logic [31:0] lim);
    n_cmp++;
    if (!(act <= lim)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected <= 0x%0h at %0t", nm, act, lim, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic logic [11:0] ref_step(input logic [11:0] s);
    int unsigned v;
    v = 32'(s);
    if (v >= 2048) v = ((v * 2) - 4096) ^ (32'h092 | 32'h1);
    else           v = v * 2;
    return 12'(v);
  endfunction

  function automatic logic [11:0] ref_mask(input logic [11:0] mx);
    int unsigned m;
    m = 0;
    while (m < 32'(mx)) m = m * 2 + 1;
    return 12'(m);
  endfunction

  logic [11:0] m_lfsr, m_max, m_mask, m_result, cand;
  logic        m_busy, m_valid, m_rej;
  int unsigned m_tries;
  bit          was_busy, accepting;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = 12'h689; m_busy = 0; m_valid = 0; m_result = 0;
      m_rej = 0; m_tries = 0; m_max = 0; m_mask = 0;
    end else begin
      was_busy  = m_busy;
      accepting = !m_busy && draw_req;
      m_valid   = 0;
      m_rej     = 0;
      if (was_busy) begin
        cand = m_lfsr & m_mask;
        if (cand <= m_max) begin
          m_result = cand; m_valid = 1; m_busy = 0;
        end else if (m_tries == MT - 1) begin
          m_result = cand / 2; m_valid = 1; m_busy = 0;
        end else begin
          m_tries++;
        end
      end else if (accepting) begin
        m_busy = 1; m_max = draw_max; m_mask = ref_mask(draw_max); m_tries = 0;
      end
      if (seed_load) begin
`ifdef RNG_ZERO_GUARD_EN
        if (seed_in == 12'h000) begin m_lfsr = 12'h689; m_rej = 1; end
        else m_lfsr = seed_in;
`else
        m_lfsr = seed_in;
`endif
      end else if (was_busy || accepting || step_en) begin
        m_lfsr = ref_step(m_lfsr);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit          prev_busy = 0;
  int          busy_run  = 0;
  logic [11:0] lat_max   = 0;
  int          valid_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("random_result", 32'(random_result), 32'(m_lfsr));
      chk("draw_busy",     32'(draw_busy),     32'(m_busy));
      chk("draw_valid",    32'(draw_valid),    32'(m_valid));
      chk("draw_result",   32'(draw_result),   32'(m_result));
      chk("seed_reject",   32'(seed_reject),   32'(m_rej));
      if (draw_valid && draw_busy) chk("valid_and_busy", 32'(1), 32'(0));
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (draw_busy && !prev_busy) lat_max = draw_max;
        if (draw_busy) busy_run++;
        if (draw_valid) begin
          valid_cnt++;
          chk_le("draw_range",   32'(draw_result), 32'(lat_max));
          chk_le("draw_latency", 32'(busy_run),    32'(MT));
          busy_run = 0;
        end
      end
    end
    prev_busy = draw_busy;
  end

  // ---------------- stimulus ----------------
  initial begin
    int i;
    int start;
    rst_n = 0; step_en = 0; seed_load = 0; seed_in = 0; draw_req = 0; draw_max = 0;
    repeat (2) @(negedge clk);
    chk("reset_random_result", 32'(random_result), 32'h689);
    chk("reset_draw_busy",     32'(draw_busy),     32'h0);
    chk("reset_draw_valid",    32'(draw_valid),    32'h0);
    chk("reset_draw_result",   32'(draw_result),   32'h0);
    chk("reset_seed_reject",   32'(seed_reject),   32'h0);
    cmp_en = 1;

    // free-running steps and hold
    step_en = 1; rst_n = 1;
    @(posedge clk); #1 chk("step1", 32'(random_result), 32'hD12);
    @(posedge clk); #1 chk("step2", 32'(random_result), 32'hAB7);
    @(negedge clk) step_en = 0;
    @(posedge clk); #1 chk("hold", 32'(random_result), 32'hAB7);

    // load beats step
    @(negedge clk) begin seed_load = 1; seed_in = 12'h123; step_en = 1; end
    @(posedge clk); #1 chk("load_wins", 32'(random_result), 32'h123);
    @(negedge clk) seed_load = 0;
    @(posedge clk); #1 chk("step_after_load", 32'(random_result), 32'h246);
    @(negedge clk) step_en = 0;

    // full-range draw on the first edge after reset
    rst_n = 0;
    @(negedge clk) begin rst_n = 1; draw_req = 1; draw_max = 12'hFFF; end
    @(posedge clk); #1 chk("first_draw_busy", 32'(draw_busy), 32'h1);
    @(negedge clk) draw_req = 0;
    @(posedge clk); #1;
    chk("first_draw_valid",  32'(draw_valid),  32'h1);
    chk("first_draw_result", 32'(draw_result), 32'hD12);

    // zero bound
    @(negedge clk) begin draw_req = 1; draw_max = 12'h000; end
    @(posedge clk); #1;
    @(negedge clk) draw_req = 0;
    @(posedge clk); #1;
    chk("zero_max_valid",  32'(draw_valid),  32'h1);
    chk("zero_max_result", 32'(draw_result), 32'h0);

    // forced fallback: every evaluation sees 0x0FF -> cand 7 > 5
    @(negedge clk) begin draw_req = 1; draw_max = 12'h005; seed_load = 1; seed_in = 12'h0FF; end
    @(posedge clk);
    @(negedge clk) draw_req = 0;
    start = 0;
    for (i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (draw_valid) begin start = i; break; end
    end
    chk("fallback_latency", 32'(start), 32'd8);
    chk("fallback_result",  32'(draw_result), 32'h3);
    @(negedge clk) seed_load = 0;

    // zero seed handling
    @(negedge clk) begin seed_load = 1; seed_in = 12'h000; end
    @(posedge clk); #1;
`ifdef RNG_ZERO_GUARD_EN
    chk("zero_seed_guarded", 32'(random_result), 32'h689);
    chk("zero_seed_reject",  32'(seed_reject),   32'h1);
    @(negedge clk) seed_load = 0;
    @(posedge clk); #1 chk("reject_one_pulse", 32'(seed_reject), 32'h0);
`else
    chk("zero_seed_loaded", 32'(random_result), 32'h000);
    @(negedge clk) begin seed_load = 0; step_en = 1; end
    repeat (3) @(posedge clk);
    #1 chk("zero_lockup", 32'(random_result), 32'h000);
    @(negedge clk) step_en = 0;
`endif

    // reset in the middle of a stalled draw
    @(negedge clk) begin seed_load = 1; seed_in = 12'hFFF; draw_req = 1; draw_max = 12'h005; end
    @(negedge clk) draw_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 0; seed_load = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1 chk("abort_no_valid", 32'(draw_valid), 32'h0);

    // 1000 back-to-back draws into 0..5
    @(negedge clk) begin seed_load = 1; seed_in = 12'h5A5; end
    @(negedge clk) begin seed_load = 0; draw_req = 1; draw_max = 12'h005; end
    start = valid_cnt;
    for (i = 0; i < 12000 && (valid_cnt - start) < 1000; i++) begin
      @(negedge clk) step_en = 1'($urandom);
    end
    chk("thousand_draws", 32'(valid_cnt - start >= 1000), 32'h1);
    draw_req = 0; step_en = 0;

    // randomized traffic
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      step_en   = 1'($urandom);
      seed_load = (($urandom % 32) == 0);
      seed_in   = (($urandom % 4) == 0) ? 12'h000 : 12'($urandom);
      draw_req  = (($urandom % 3) == 0);
      case ($urandom % 4)
        0:       draw_max = 12'h000;
        1:       draw_max = 12'($urandom % 8);
        2:       draw_max = 12'($urandom);
        default: draw_max = 12'h800 | 12'($urandom % 16);
      endcase
    end
    @(negedge clk) begin draw_req = 0; seed_load = 0; step_en = 0; end
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
